// File: rtl/alu_mbyte_seq_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: the alu_unit opcode
// values, the sequencer state encoding (visible for debug decode), and small
// opcode helpers.
package alu_mbyte_seq_pkg;

  // Opcode values understood by the 8-bit alu_unit.
  localparam logic [3:0] ALU_ADC = 4'h0;
  localparam logic [3:0] ALU_SBC = 4'h1;
  localparam logic [3:0] ALU_ORA = 4'h2;
  localparam logic [3:0] ALU_AND = 4'h3;
  localparam logic [3:0] ALU_EOR = 4'h4;
  localparam logic [3:0] ALU_ROR = 4'h5;
  localparam logic [3:0] ALU_PSA = 4'h6;

  // Sequencer states; the encoding is fixed so debug logic can decode it.
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_RUN  = 2'd1,
    SEQ_DONE = 2'd2
  } seq_state_e;

  // Opcode actually issued to alu_unit: anything unrecognised becomes a pass.
  function automatic logic [3:0] issue_op(input logic [3:0] op);
    case (op)
      ALU_ADC, ALU_SBC, ALU_ORA, ALU_AND,
      ALU_EOR, ALU_ROR, ALU_PSA: return op;
      default:                   return ALU_PSA;
    endcase
  endfunction

  // Only the arithmetic and rotate ops pass carry from byte to byte.
  function automatic logic chains_carry(input logic [3:0] op);
    return (op == ALU_ADC) || (op == ALU_SBC) || (op == ALU_ROR);
  endfunction

endpackage

// File: rtl/alu_mbyte_seq.sv
// Multi-byte ALU sequencer. Runs one 8*NBYTES-bit operation through the
// external combinational 8-bit alu_unit, one byte per enabled cycle, chaining
// carry between bytes and assembling a registered result plus flags.
module alu_mbyte_seq
  import alu_mbyte_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ready,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [8*NBYTES-1:0]   opa,
  input  logic [8*NBYTES-1:0]   opb,
  input  logic                  c_in,
  output logic                  busy,
  output logic                  done,
  output logic [8*NBYTES-1:0]   result,
  output logic                  c_out,
  output logic                  v_out,
  output logic                  n_out,
  output logic                  z_out,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_c_in,
  output logic                  alu_dec_add,
  output logic [3:0]            alu_op,
  input  logic [7:0]            alu_out,
  input  logic                  alu_carry_out,
  input  logic                  alu_overflow_out
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NBYTES - 1);

  seq_state_e        r_state;
  seq_state_e        w_state_next;
  logic [3:0]        r_op;
  logic [W-1:0]      r_opa;
  logic [W-1:0]      r_opb;
  logic              r_carry;
  logic [IDX_W-1:0]  r_idx;
  logic [W-1:0]      r_result;
  logic              r_c;
  logic              r_v;
  logic              r_n;
  logic              r_z;

  logic [IDX_W+2:0]  w_bit_base;
  logic [7:0]        w_b_byte;
  logic              w_is_ror;
  logic              w_last;
  logic [W-1:0]      w_next_result;
  logic [3:0]        w_accept_op;

  assign w_bit_base  = {r_idx, 3'b000};
  assign w_b_byte    = r_opb[w_bit_base +: 8];
  assign w_is_ror    = (r_op == ALU_ROR);
  assign w_last      = w_is_ror ? (r_idx == '0) : (r_idx == IDX_MSB);
  assign w_accept_op = issue_op(op);

  // Byte operands to alu_unit; SBC feeds ~B so the adder computes A + ~B + C.
  assign alu_a       = r_opa[w_bit_base +: 8];
  assign alu_b       = (r_op == ALU_SBC) ? ~w_b_byte : w_b_byte;
  assign alu_c_in    = r_carry;
  assign alu_op      = r_op;
  assign alu_dec_add = 1'b0;

  assign busy   = (r_state != SEQ_IDLE);
  assign done   = (r_state == SEQ_DONE);
  assign result = r_result;
  assign c_out  = r_c;
  assign v_out  = r_v;
  assign n_out  = r_n;
  assign z_out  = r_z;

  // Result with the current alu_unit byte inserted at the active index.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_next_result = r_result;
    w_next_result[w_bit_base +: 8] = alu_out;
  end

  // State register; reset wins over the clock enable.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_state <= SEQ_IDLE;
    end else if (ready) begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      SEQ_IDLE: if (start)  w_state_next = SEQ_RUN;
      SEQ_RUN:  if (w_last) w_state_next = SEQ_DONE;
      SEQ_DONE: w_state_next = SEQ_IDLE;
      default:  w_state_next = SEQ_IDLE;
    endcase
  end

  // Operand latch, byte capture, carry chain, index stepping and flags.
  always_ff @(posedge clk) begin
    // NOTE: the operand latches are cleared on reset too; they are ordinary
    // flops, not a RAM, so resetting them costs nothing and keeps the ALU
    // drive deterministic out of reset.
    if (!reset_n) begin
      r_op     <= ALU_ADC;
      r_opa    <= '0;
      r_opb    <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_result <= '0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
      r_n      <= 1'b0;
      r_z      <= 1'b0;
    end else if (ready) begin
      case (r_state)
        SEQ_IDLE: begin
          if (start) begin
            r_op     <= w_accept_op;
            r_opa    <= opa;
            r_opb    <= opb;
            r_carry  <= c_in;
            r_idx    <= (w_accept_op == ALU_ROR) ? IDX_MSB : '0;
            r_result <= '0;
          end
        end
        SEQ_RUN: begin
          r_result <= w_next_result;
          if (chains_carry(r_op)) begin
            r_carry <= alu_carry_out;
          end
          r_idx <= w_is_ror ? (r_idx - IDX_W'(1)) : (r_idx + IDX_W'(1));
          if (w_last) begin
            r_c <= chains_carry(r_op) ? alu_carry_out : r_carry;
            r_v <= ((r_op == ALU_ADC) || (r_op == ALU_SBC)) ? alu_overflow_out : 1'b0;
            r_n <= w_next_result[W-1];
            r_z <= (w_next_result == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mbyte_seq.sv
// Testbench for alu_mbyte_seq: a behavioural 8-bit alu_unit sits next to the
// sequencer; a driver issues directed and random operations and pushes the
// expected full-width results into a scoreboard that a monitor checks.
module tb_alu_mbyte_seq;
  import alu_mbyte_seq_pkg::*;

  localparam int NBYTES = 4;
  localparam int W      = 8 * NBYTES;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         v;
    logic         n;
    logic         z;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           ready;
  logic           start;
  logic [3:0]     op;
  logic [W-1:0]   opa;
  logic [W-1:0]   opb;
  logic           c_in;
  logic           busy;
  logic           done;
  logic [W-1:0]   result;
  logic           c_out, v_out, n_out, z_out;
  logic [7:0]     alu_a, alu_b;
  logic           alu_c_in;
  logic           alu_dec_add;
  logic [3:0]     alu_op;
  logic [7:0]     alu_out;
  logic           alu_carry_out;
  logic           alu_overflow_out;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_mbyte_seq #(.NBYTES(NBYTES)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ready            (ready),
    .start            (start),
    .op               (op),
    .opa              (opa),
    .opb              (opb),
    .c_in             (c_in),
    .busy             (busy),
    .done             (done),
    .result           (result),
    .c_out            (c_out),
    .v_out            (v_out),
    .n_out            (n_out),
    .z_out            (z_out),
    .alu_a            (alu_a),
    .alu_b            (alu_b),
    .alu_c_in         (alu_c_in),
    .alu_dec_add      (alu_dec_add),
    .alu_op           (alu_op),
    .alu_out          (alu_out),
    .alu_carry_out    (alu_carry_out),
    .alu_overflow_out (alu_overflow_out)
  );

  // Stand-in alu_unit. The SBC path adds whatever B it is given. AND reports
  // a bit-test carry and non-add ops report A[6] as overflow, both of which
  // the sequencer must ignore.
  always_comb begin
    logic [8:0] sum;
    sum              = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_c_in};
    alu_out          = alu_a;
    alu_carry_out    = alu_c_in;
    alu_overflow_out = alu_a[6];
    case (alu_op)
      ALU_ADC, ALU_SBC: begin
        alu_out          = sum[7:0];
        alu_carry_out    = sum[8];
        alu_overflow_out = (alu_a[7] == alu_b[7]) && (sum[7] != alu_a[7]);
      end
      ALU_ORA: alu_out = alu_a | alu_b;
      ALU_AND: begin
        alu_out       = alu_a & alu_b;
        alu_carry_out = |(alu_a & alu_b);
      end
      ALU_EOR: alu_out = alu_a ^ alu_b;
      ALU_ROR: begin
        alu_out       = {alu_c_in, alu_a[7:1]};
        alu_carry_out = alu_a[0];
      end
      default: alu_out = alu_a;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Whole-operand reference: plain wide arithmetic on the full words.
  function automatic exp_t ref_model(input logic [3:0] o, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic ci);
    exp_t       e;
    logic [W:0] sum;
    logic [W-1:0] bb;
    e.res = a;
    e.c   = ci;
    e.v   = 1'b0;
    case (o)
      ALU_ADC, ALU_SBC: begin
        bb    = (o == ALU_SBC) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, ci};
        e.res = sum[W-1:0];
        e.c   = sum[W];
        e.v   = (a[W-1] == bb[W-1]) && (e.res[W-1] != a[W-1]);
      end
      ALU_ORA: e.res = a | b;
      ALU_AND: e.res = a & b;
      ALU_EOR: e.res = a ^ b;
      ALU_ROR: begin
        e.res = {ci, a[W-1:1]};
        e.c   = a[0];
      end
      default: e.res = a;
    endcase
    e.n = e.res[W-1];
    e.z = (e.res == '0);
    return e;
  endfunction

  // Monitor: every completed operation is checked against the scoreboard.
  always @(negedge clk) begin
    if (reset_n && done && ready) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("c_out", c_out, e.c);
        check("v_out", v_out, e.v);
        check("n_out", n_out, e.n);
        check("z_out", z_out, e.z);
      end
    end
  end

  // Issue one operation. ready is dropped after edge stall_at for stall_len
  // edges; poke re-asserts start mid-run; abort_at>=0 resets after that edge.
  task automatic run_op(input logic [3:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input int stall_at, input int stall_len,
                        input bit poke, input int abort_at);
    int e;
    bit seen;
    int dcount;
    @(posedge clk); #2;
    op = o; opa = a; opb = b; c_in = ci; start = 1'b1; ready = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    op = 4'($urandom); opa = W'($urandom); opb = W'($urandom); c_in = 1'($urandom);
    if (abort_at < 0) sb.push_back(ref_model(o, a, b, ci));
    check("busy_after_accept", busy, 1'b1);
    e = 0;
    seen = 1'b0;
    while (!seen && e <= 60) begin
      if (e > 0 && done) begin
        seen = 1'b1;
        check("done_latency", e, NBYTES + stall_len);
      end else if (e == abort_at) begin
        reset_n = 1'b0;
        start = 1'b0;
        @(posedge clk); #2;
        reset_n = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_result", result, '0);
        check("abort_flags", {c_out, v_out, n_out, z_out}, 4'b0000);
        dcount = 0;
        for (int i = 0; i < 8; i++) begin
          @(posedge clk); #2;
          if (done) dcount++;
        end
        check("abort_no_done", dcount, 0);
        return;
      end else begin
        ready = !(e >= stall_at && e < stall_at + stall_len);
        start = poke && (e == 1);
        @(posedge clk); #2;
        start = 1'b0;
        e++;
      end
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    ready = 1'b1;
    start = 1'b0;
    @(posedge clk); #2;
    check("idle_after_done", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] rop;
    reset_n = 1'b0; ready = 1'b0; start = 1'b0;
    op = ALU_ADC; opa = '0; opb = '0; c_in = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_result", result, '0);
    check("reset_flags", {c_out, v_out, n_out, z_out}, 4'b0000);
    check("dec_add_tied", alu_dec_add, 1'b0);
    reset_n = 1'b1; ready = 1'b1;

    run_op(ALU_ADC, 32'h0000FFFF, 32'h00000001, 1'b0, 0, 0, 1'b0, -1);
    run_op(ALU_SBC, 32'h00000000, 32'h00000001, 1'b1, 0, 0, 1'b0, -1);
    run_op(ALU_ADC, 32'h7FFFFFFF, 32'h00000001, 1'b0, 0, 0, 1'b0, -1);
    run_op(ALU_ROR, 32'h00000003, 32'h5A5A5A5A, 1'b1, 0, 0, 1'b0, -1);
    run_op(ALU_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 1'b1, 0, 0, 1'b0, -1);
    run_op(ALU_ADC, 32'h12345678, 32'h11111111, 1'b0, 2, 3, 1'b1, -1);
    run_op(ALU_ADC, 32'h12345678, 32'h11111111, 1'b0, 0, 0, 1'b0, 2);
    run_op(ALU_ADC, 32'h00000001, 32'h00000001, 1'b0, 0, 0, 1'b0, -1);
    run_op(4'hC,    32'hDEADBEEF, 32'h01234567, 1'b1, 0, 0, 1'b0, -1);

    for (int n = 0; n < 30; n++) begin
      rop = 4'($urandom_range(0, 8));
      if (rop == 4'd7) rop = 4'hA;
      if (rop == 4'd8) rop = 4'hF;
      run_op(rop, W'($urandom), W'($urandom), 1'($urandom),
             $urandom_range(1, NBYTES - 1), $urandom_range(0, 3),
             1'($urandom), -1);
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mbyte_seq.md
Name: alu_mbyte_seq

Overview:
- Multi-byte sequencer for the 8-bit core ALU (alu_unit).
- Runs one 8*NBYTES-bit ADC/SBC/ORA/AND/EOR/ROR/PSA operation by issuing one byte per enabled cycle to the external, combinational alu_unit. Each returned byte is captured, and carry is chained between bytes.
- Used for 45GS02-style 32-bit Q-register operations. Sits between the CPU microsequencer and the existing ALU input muxing.

Parameters:
- NBYTES, 4, operand width in bytes; legal range 2..8.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- ready  in  1  clock enable; when low, all state and outputs hold.
- start  in  1  request; accepted only in IDLE with ready=1.
- op  in  4  ALU_* opcode from the shared include.
- opa  in  8*NBYTES  operand A; latched at accept.
- opb  in  8*NBYTES  operand B; latched at accept.
- c_in  in  1  initial carry.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse; result and flags valid.
- result  out  8*NBYTES  registered result.
- c_out, v_out, n_out, z_out  out  1 each  registered flags.
- alu_a, alu_b  out  8 each  byte operands to alu_unit.
- alu_c_in  out  1  carry to alu_unit.
- alu_dec_add  out  1  tied 0; decimal mode is not supported multi-byte.
- alu_op  out  4  opcode to alu_unit.
- alu_out  in  8  alu_unit result byte.
- alu_carry_out  in  1  alu_unit carry out.
- alu_overflow_out  in  1  alu_unit overflow.

Behaviour:
- Reset (reset_n=0 at an edge): state IDLE; busy=0, done=0; result=0; c_out=v_out=n_out=z_out=0; internal latches, index and carry cleared. Reset takes priority over ready. Reset mid-operation aborts with no done pulse.
- States: IDLE, RUN, DONE. No transition or register update occurs while ready=0.
- IDLE:
  - start=1 latches op, opa, opb and c_in into the chain carry.
  - Byte index starts at 0 (LSB) for all ops except ROR, which starts at NBYTES-1 (MSB).
  - Clears the result accumulator, then goes to RUN.
- RUN, combinational drive:
  - alu_a = latched A byte[idx]; alu_b = latched B byte[idx]; alu_c_in = chain carry; alu_op = latched op.
  - For SBC, alu_b is the ones-complement of the B byte, so the 8-bit adder performs A + ~B + C.
  - Unlisted opcodes are issued as ALU_PSA.
- RUN, each ready edge:
  - result byte[idx] <= alu_out.
  - ADC/SBC/ROR: chain carry <= alu_carry_out.
  - ORA/AND/EOR/PSA: chain carry holds. This discards the AND bit-test carry.
  - idx steps +1, or -1 for ROR.
  - After the final byte (idx NBYTES-1, or 0 for ROR), go to DONE.
- Flag update, on the same edge as the final byte:
  - c_out = final chain carry.
  - v_out = alu_overflow_out of the MSB byte for ADC/SBC, else 0.
  - n_out = MSB of the assembled result.
  - z_out = 1 iff the full assembled result is zero, including the final byte.
- DONE: done=1 for one ready cycle, then IDLE. Result and flags hold until the next accept.
- Latency: accept at edge k; bytes captured at edges k+1..k+NBYTES (ready cycles only); done high in the cycle after edge k+NBYTES.
- start while busy is ignored; no queuing.
- Operand inputs may change after accept without effect.

Decomposition:
- ALU_* opcode macros come from the existing 6502_inc.vh; no new opcodes.
- Add SEQ_IDLE/SEQ_RUN/SEQ_DONE state encodings to 6502_inc.vh so the microsequencer can decode them for debug.
- No sub-module: byte select and byte insert are inline muxes.
- alu_unit stays external so the ALU can still be shared with the 8-bit path. The bench instantiates alu_unit next to the sequencer.

Test Plan (NBYTES=4, ready=1 unless stated):
- ADC, opa=0x0000FFFF, opb=0x00000001, c_in=0 -> result 0x00010000; C=0, V=0, N=0, Z=0; done exactly 5 cycles after start asserted (start edge + 4).
- SBC, opa=0x00000000, opb=0x00000001, c_in=1 -> result 0xFFFFFFFF; C=0, N=1, V=0, Z=0.
- ADC, opa=0x7FFFFFFF, opb=0x00000001, c_in=0 -> result 0x80000000; V=1, N=1, C=0.
- ROR, opa=0x00000003, c_in=1 -> result 0x80000001; C=1, N=1. AND, 0xF0F0F0F0 & 0x0F0F0F0F, c_in=1 -> result 0, Z=1, C=1.
- ADC 0x12345678 + 0x11111111 with ready low for 3 cycles during byte 2 -> result 0x23456789; done delayed by exactly 3 cycles; start pulses during RUN are ignored.
- reset_n low during byte 2 of an ADC -> next edge busy=0, done=0, result=0, flags=0, no done pulse. A following ADC 1+1 yields 0x00000002.
